lmdpl_and_tree: RTL and testbench
=================================

// Module: lmdpl_and_tree
// PURPOSE
//   N_IN-input AND reduction built as a binary tree of first-order LMDPL AND gadgets (N_IN-1 gadgets, LEVELS=log2(N_IN)).
//   Two-phase operation: mask phase builds and registers every gadget's 8-bit mask table; value phase evaluates the dual-rail tree one level per cycle.
//   Generalises the fixed 3-gadget chain; used as the wide-AND primitive in masked S-box / comparator datapaths.
// PARAMETERS
//   N_IN    4   number of AND operands; power of two, 2..32
//   LEVELS  $clog2(N_IN)   derived; not overridable
// PORTS
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous reset, active-low
//   m_valid    in   1        mask phase request
//   m_ready    out  1        mask phase accept (high only in IDLE)
//   a_m        in   N_IN     operand masks (LMDPL share 1)
//   r          in   N_IN-1   fresh mask per gadget; index g = gadget g in breadth-first order, leaves first
//   v_valid    in   1        value phase request
//   v_ready    out  1        value phase accept (high only in MASKED)
//   a_v        in   N_IN     masked operand true rail (a ^ a_m)
//   a_v_bar    in   N_IN     masked operand false rail
//   out_valid  out  1        one-cycle pulse: result valid
//   x_m        out  1        result mask (= r[N_IN-2], root gadget)
//   x_v        out  1        result true rail (AND(a) ^ x_m)
//   x_v_bar    out  1        result false rail
//   dr_err     out  1        sticky dual-rail error (LMDPL_DR_CHECK_EN only, else tied 0)
// BEHAVIOUR
//   Reset: state=IDLE, all mask tables, dual-rail regs, x_m, x_v, x_v_bar, out_valid, dr_err = 0.
//   FSM: IDLE -> MASKED -> EVAL -> DONE -> PRE -> IDLE.
//   IDLE: m_ready=1; on m_valid: tables for all gadgets computed from a_m and r (gadget output mask = its r bit, fed as child mask to its parent) and registered; -> MASKED.
//   MASKED: v_ready=1; waits indefinitely; on v_valid: a_v/a_v_bar registered into level-0 dual-rail regs, lvl_cnt=0; -> EVAL.
//   EVAL: each cycle, level lvl_cnt gadgets evaluate from registered tables and registered dual-rail inputs into level lvl_cnt+1 regs; lvl_cnt++; after LEVELS cycles -> DONE.
//   DONE: out_valid=1 for exactly one cycle; x_v/x_v_bar/x_m driven from root regs; -> PRE.
//   PRE: all dual-rail regs (incl. outputs x_v, x_v_bar) cleared to 0 (precharge); x_m held; -> IDLE.
//   Latency: v_valid accept to out_valid = LEVELS+1 cycles; full op min LEVELS+4 cycles.
//   Dual-rail regs only ever transition 0->value->0; never value->value. Mask tables never change during EVAL.
//   m_valid in non-IDLE and v_valid outside MASKED are ignored (no queueing).
//   Unmasked values never formed: no XOR of a_m with a_v anywhere in RTL.
//   Async reset mid-operation: immediate return to reset state; partial result discarded.
// CONFIGURATION
//   LMDPL_DR_CHECK_EN defined: in EVAL/DONE, any registered dual-rail pair equal (00 or 11) sets dr_err; cleared only by reset.
//   Undefined: no checker logic; dr_err tied 0.
// STRUCTURE
//   lmdpl_pkg: state enum (IDLE, MASKED, EVAL, DONE, PRE), LMDPL_TBL_W=8, gadget index helpers (child/parent of gadget g).
//   Sub-module lmdpl_and_gadget: purely combinational; mask-table generator (a1,b1,r -> t[7:0]) plus dual-rail AND3/OR4 evaluator (t, a2/a2_bar, b2/b2_bar -> x2/x2_bar). Top owns all registers and FSM.
// TESTING
//   Reset: rst=0 mid-EVAL -> next cycle all outputs 0, m_ready=1.
//   N_IN=4, a=4'b1111, a_m=4'b1010, r=3'b101: full op -> out_valid at v-accept+3, x_m=1, x_v=0, x_v_bar=1 (AND=1).
//   N_IN=4, a=4'b1101, same masks -> x_m=1, x_v=1, x_v_bar=0 (AND=0).
//   Exhaustive N_IN=4: all 16 a x random a_m, r -> x_v^x_m == &a, x_v != x_v_bar every op.
//   Handshake: v_valid held in IDLE, m_valid held in EVAL -> ignored; v_ready low until mask accept; out_valid single pulse.
//   LMDPL_DR_CHECK_EN: force a_v[0]=a_v_bar[0]=1 -> dr_err=1 at first EVAL cycle, stays 1 until reset.

Source files
------------

// File: rtl/lmdpl_pkg.sv
// Shared types and index helpers for the LMDPL AND tree.
// Node numbering: nodes 0..N_IN-1 are operands, node N_IN+g is the output of gadget g.
package lmdpl_pkg;

  localparam int LMDPL_TBL_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MASKED = 3'd1,
    EVAL   = 3'd2,
    DONE   = 3'd3,
    PRE    = 3'd4
  } lmdpl_state_e;

  // Child k (0/1) of gadget g, as a node index.
  function automatic int lmdpl_child_node(int g, int k);
    return 2 * g + k;
  endfunction

  // Gadget fed by gadget g's output.
  function automatic int lmdpl_parent_gadget(int g, int n_in);
    return (n_in + g) / 2;
  endfunction

  // Tree level of gadget g (leaf gadgets are level 0).
  function automatic int lmdpl_gadget_level(int g, int n_in);
    int base  = 0;
    int width = n_in / 2;
    int lvl   = 0;
    for (int l = 0; l < 6; l++) begin
      if ((g >= base + width) && (width > 1)) begin
        base  = base + width;
        width = width / 2;
        lvl   = lvl + 1;
      end
    end
    return lvl;
  endfunction

  // Level at which node n carries a valid dual-rail value.
  function automatic int lmdpl_node_level(int n, int n_in);
    if (n < n_in) return 0;
    return lmdpl_gadget_level(n - n_in, n_in) + 1;
  endfunction

endpackage

// File: rtl/lmdpl_and_gadget.sv
// First-order LMDPL AND gadget: mask-table generator plus dual-rail AND3/OR4 evaluator.
// Purely combinational; the enclosing tree registers the table and the rails.
module lmdpl_and_gadget
  import lmdpl_pkg::*;
(
  input  logic                   i_a1,
  input  logic                   i_b1,
  input  logic                   i_r,
  output logic [LMDPL_TBL_W-1:0] o_t,
  input  logic [LMDPL_TBL_W-1:0] i_t,
  input  logic                   i_a2,
  input  logic                   i_a2_bar,
  input  logic                   i_b2,
  input  logic                   i_b2_bar,
  output logic                   o_x2,
  output logic                   o_x2_bar
);

  logic [3:0] w_t_true;
  logic [3:0] w_sel;

  // Entry {a2,b2} holds ((a2^a1)&(b2^b1))^r with the masked index fixed per entry.
  always_comb begin
    w_t_true    = '0;
    w_t_true[0] = (i_a1 & i_b1) ^ i_r;
    w_t_true[1] = (i_a1 & ~i_b1) ^ i_r;
    w_t_true[2] = (~i_a1 & i_b1) ^ i_r;
    w_t_true[3] = (~i_a1 & ~i_b1) ^ i_r;
  end

  assign o_t = {~w_t_true, w_t_true};

  // Exactly one select is high for a valid pair; all are low while precharged.
  assign w_sel = {i_a2 & i_b2, i_a2 & i_b2_bar, i_a2_bar & i_b2, i_a2_bar & i_b2_bar};

  assign o_x2     = |(i_t[3:0] & w_sel);
  assign o_x2_bar = |(i_t[7:4] & w_sel);

endmodule

// File: rtl/lmdpl_and_tree.sv
// N_IN-input masked AND reduction built from LMDPL gadgets, evaluated one tree level per cycle.
// Optional macro LMDPL_DR_CHECK_EN adds a sticky dual-rail consistency checker on dr_err.
module lmdpl_and_tree
  import lmdpl_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_valid,
  output logic            m_ready,
  input  logic [N_IN-1:0] a_m,
  input  logic [N_IN-2:0] r,
  input  logic            v_valid,
  output logic            v_ready,
  input  logic [N_IN-1:0] a_v,
  input  logic [N_IN-1:0] a_v_bar,
  output logic            out_valid,
  output logic            x_m,
  output logic            x_v,
  output logic            x_v_bar,
  output logic            dr_err,
  output logic [2:0]      dbg_state
);

  localparam int LEVELS = $clog2(N_IN);
  localparam int NODES  = 2 * N_IN - 1;
  localparam int LVL_W  = $clog2(LEVELS + 1);

  lmdpl_state_e           r_state;
  logic [LVL_W-1:0]       r_lvl;
  logic [LMDPL_TBL_W-1:0] r_tbl [N_IN-1];
  logic [NODES-1:0]       r_nv;
  logic [NODES-1:0]       r_nvb;
  logic                   r_root_m;
  logic                   r_out_valid;
  logic                   r_x_m;
  logic                   r_x_v;
  logic                   r_x_v_bar;

  logic [NODES-1:0]       w_node_m;
  logic [LMDPL_TBL_W-1:0] w_tbl [N_IN-1];
  logic [N_IN-2:0]        w_x;
  logic [N_IN-2:0]        w_xb;

  // Handshakes: a request (m_valid / v_valid) is taken on a rising edge where
  // the matching ready is high; requests while ready is low are dropped, not queued.
  assign m_ready   = (r_state == IDLE);
  assign v_ready   = (r_state == MASKED);
  assign out_valid = r_out_valid;
  assign x_m       = r_x_m;
  assign x_v       = r_x_v;
  assign x_v_bar   = r_x_v_bar;
  assign dbg_state = r_state;

  assign w_node_m = {r, a_m};

  for (genvar g = 0; g < N_IN - 1; g++) begin : g_gadget
    localparam int CA = lmdpl_child_node(g, 0);
    localparam int CB = lmdpl_child_node(g, 1);
    lmdpl_and_gadget u_gadget (
      .i_a1     (w_node_m[CA]),
      .i_b1     (w_node_m[CB]),
      .i_r      (r[g]),
      .o_t      (w_tbl[g]),
      .i_t      (r_tbl[g]),
      .i_a2     (r_nv[CA]),
      .i_a2_bar (r_nvb[CA]),
      .i_b2     (r_nv[CB]),
      .i_b2_bar (r_nvb[CB]),
      .o_x2     (w_x[g]),
      .o_x2_bar (w_xb[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_lvl       <= '0;
      r_nv        <= '0;
      r_nvb       <= '0;
      r_root_m    <= 1'b0;
      r_out_valid <= 1'b0;
      r_x_m       <= 1'b0;
      r_x_v       <= 1'b0;
      r_x_v_bar   <= 1'b0;
      for (int g = 0; g < N_IN - 1; g++) r_tbl[g] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (m_valid) begin
            for (int g = 0; g < N_IN - 1; g++) r_tbl[g] <= w_tbl[g];
            r_root_m <= w_node_m[NODES-1];
            r_state  <= MASKED;
          end
        end
        MASKED: begin
          if (v_valid) begin
            r_nv[N_IN-1:0]  <= a_v;
            r_nvb[N_IN-1:0] <= a_v_bar;
            r_lvl           <= '0;
            r_state         <= EVAL;
          end
        end
        EVAL: begin
          // Only the current level latches, so every rail goes 0 -> value exactly once.
          for (int g = 0; g < N_IN - 1; g++) begin
            if (lmdpl_gadget_level(g, N_IN) == int'(r_lvl)) begin
              r_nv[N_IN+g]  <= w_x[g];
              r_nvb[N_IN+g] <= w_xb[g];
            end
          end
          r_lvl <= r_lvl + LVL_W'(1);
          if (r_lvl == LVL_W'(LEVELS - 1)) r_state <= DONE;
        end
        DONE: begin
          r_out_valid <= 1'b1;
          r_x_m       <= r_root_m;
          r_x_v       <= r_nv[NODES-1];
          r_x_v_bar   <= r_nvb[NODES-1];
          r_state     <= PRE;
        end
        PRE: begin
          r_out_valid <= 1'b0;
          r_x_v       <= 1'b0;
          r_x_v_bar   <= 1'b0;
          r_nv        <= '0;
          r_nvb       <= '0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef LMDPL_DR_CHECK_EN
  logic w_dr_bad;
  logic r_dr_err;

  // A pair is checked once its level has been loaded; unloaded nodes are still precharged.
  always_comb begin
    w_dr_bad = 1'b0;
    for (int n = 0; n < NODES; n++) begin
      if (((r_state == EVAL) && (lmdpl_node_level(n, N_IN) <= int'(r_lvl))) ||
          (r_state == DONE)) begin
        if (r_nv[n] == r_nvb[n]) w_dr_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_dr_err <= 1'b0;
    else if (w_dr_bad) r_dr_err <= 1'b1;
  end

  assign dr_err = r_dr_err;
`else
  assign dr_err = 1'b0;
`endif

endmodule

// File: tb/tb_lmdpl_and_tree.sv
// Self-checking bench for lmdpl_and_tree (N_IN=4) against a plain AND/XOR reference model.
module tb_lmdpl_and_tree;
  import lmdpl_pkg::*;

  localparam int N      = 4;
  localparam int LEVELS = 2;
`ifdef LMDPL_DR_CHECK_EN
  localparam logic DR_EN = 1'b1;
`else
  localparam logic DR_EN = 1'b0;
`endif

  logic         clk, rst, m_valid, m_ready, v_valid, v_ready;
  logic [N-1:0] a_m, a_v, a_v_bar;
  logic [N-2:0] r_in;
  logic         out_valid, x_m, x_v, x_v_bar, dr_err;
  logic [2:0]   dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [2:0] exp_q[$];

  lmdpl_and_tree #(.N_IN(N)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_ready(m_ready), .a_m(a_m), .r(r_in),
    .v_valid(v_valid), .v_ready(v_ready), .a_v(a_v), .a_v_bar(a_v_bar),
    .out_valid(out_valid), .x_m(x_m), .x_v(x_v), .x_v_bar(x_v_bar),
    .dr_err(dr_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b0;
    m_valid = 1'b0; v_valid = 1'b0;
    a_m = '0; r_in = '0; a_v = '0; a_v_bar = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] model(input logic [N-1:0] a, input logic [N-2:0] rr);
    logic xm, xv;
    xm = rr[N-2];
    xv = (&a) ^ xm;
    return {xm, xv, ~xv};
  endfunction

  // ---------------- driver ----------------
  // Runs one full operation; all sampling is 1 time unit after the rising edge.
  task automatic run_op(input logic [N-1:0] am, input logic [N-2:0] rr,
                        input logic [N-1:0] av, input logic [N-1:0] avb,
                        input int v_delay, input bit m_hold,
                        output int lat, output int cyc, output logic [2:0] res,
                        output logic [3:0] after, output logic vrdy, output logic mrdy_eval);
    int w;
    lat = -1; cyc = 0; res = '0; after = '0; vrdy = 1'b0; mrdy_eval = 1'b0;
    w = 0;
    while (!m_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!m_ready) return;
    m_valid = 1'b1; a_m = am; r_in = rr;
    @(posedge clk); #1;
    m_valid = 1'b0; cyc = 1;
    repeat (v_delay) begin
      @(posedge clk); #1; cyc++;
    end
    vrdy = v_ready;
    v_valid = 1'b1; a_v = av; a_v_bar = avb;
    @(posedge clk); #1;
    v_valid = 1'b0; cyc++;
    if (m_hold) m_valid = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1; cyc++;
      if (m_hold && m_ready) mrdy_eval = 1'b1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    m_valid = 1'b0;
    res = {x_m, x_v, x_v_bar};
    a_v = '0; a_v_bar = '0;
    @(posedge clk); #1; cyc++;
    after = {out_valid, x_m, x_v, x_v_bar};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if ({x_m, x_v, x_v_bar} !== 3'b000) begin failures++; $display("FAIL rst_outputs got=%b exp=000", {x_m, x_v, x_v_bar}); end
    checks++; if (dr_err !== 1'b0) begin failures++; $display("FAIL rst_dr_err got=%b exp=0", dr_err); end
    checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL rst_m_ready got=%b exp=1", m_ready); end
    checks++; if (v_ready !== 1'b0) begin failures++; $display("FAIL rst_v_ready got=%b exp=0", v_ready); end
    checks++; if (dbg_state !== 3'(IDLE)) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_directed();
    logic [N-1:0] a_tab [2];
    logic [2:0]   exp_tab [2];
    logic [N-1:0] am;
    logic [N-2:0] rr;
    int lat, cyc;
    logic [2:0] res;
    logic [3:0] after;
    logic vrdy, mre;
    a_tab[0] = 4'b1111; exp_tab[0] = 3'b101;
    a_tab[1] = 4'b1101; exp_tab[1] = 3'b110;
    am = 4'b1010; rr = 3'b101;
    for (int i = 0; i < 2; i++) begin
      run_op(am, rr, a_tab[i] ^ am, ~(a_tab[i] ^ am), 0, 1'b0, lat, cyc, res, after, vrdy, mre);
      checks++; if (lat !== LEVELS + 1) begin failures++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, LEVELS + 1); end
      checks++; if (res !== exp_tab[i]) begin failures++; $display("FAIL dir%0d_result got=%b exp=%b", i, res, exp_tab[i]); end
      checks++; if (after !== {1'b0, exp_tab[i][2], 2'b00}) begin failures++; $display("FAIL dir%0d_precharge got=%b exp=%b", i, after, {1'b0, exp_tab[i][2], 2'b00}); end
      checks++; if (cyc !== LEVELS + 4) begin failures++; $display("FAIL dir%0d_op_cycles got=%0d exp=%0d", i, cyc, LEVELS + 4); end
    end
  endtask

  task automatic test_mid_reset();
    m_valid = 1'b1; a_m = 4'b0110; r_in = 3'b100;
    @(posedge clk); #1;
    m_valid = 1'b0; v_valid = 1'b1; a_v = 4'b1001; a_v_bar = 4'b0110;
    @(posedge clk); #1;
    v_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checks++; if ({out_valid, x_m, x_v, x_v_bar, dr_err} !== 5'b0) begin failures++; $display("FAIL midrst_outputs got=%b exp=00000", {out_valid, x_m, x_v, x_v_bar, dr_err}); end
    checks++; if ({m_ready, v_ready} !== 2'b10) begin failures++; $display("FAIL midrst_ready got=%b exp=10", {m_ready, v_ready}); end
    a_v = '0; a_v_bar = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive();
    logic [N-1:0] am;
    logic [N-2:0] rr;
    logic [2:0] exp_v, res;
    logic [3:0] after;
    int lat, cyc;
    logic vrdy, mre;
    for (int a = 0; a < 16; a++) begin
      am = 4'($urandom_range(0, 15));
      rr = 3'($urandom_range(0, 7));
      exp_q.push_back(model(4'(a), rr));
      run_op(am, rr, 4'(a) ^ am, ~(4'(a) ^ am), 0, 1'b0, lat, cyc, res, after, vrdy, mre);
      exp_v = exp_q.pop_front();
      checks++; if (res !== exp_v) begin failures++; $display("FAIL exh_result a=%h am=%h r=%h got=%b exp=%b", a, am, rr, res, exp_v); end
      checks++; if ((res[1] ^ res[2]) !== (&4'(a))) begin failures++; $display("FAIL exh_unmask a=%h got=%b exp=%b", a, res[1] ^ res[2], &4'(a)); end
      checks++; if (res[1] === res[0]) begin failures++; $display("FAIL exh_dual_rail a=%h got=%b%b exp=complementary", a, res[1], res[0]); end
      checks++; if (lat !== LEVELS + 1) begin failures++; $display("FAIL exh_latency a=%h got=%0d exp=%0d", a, lat, LEVELS + 1); end
      checks++; if (dr_err !== 1'b0) begin failures++; $display("FAIL exh_dr_err a=%h got=%b exp=0", a, dr_err); end
    end
  endtask

  task automatic test_handshake();
    logic [2:0] exp_v, res;
    logic [3:0] after;
    int lat, cyc, bad_v, bad_ov;
    logic vrdy, mre;
    logic [N-1:0] av;
    bad_v = 0; bad_ov = 0;
    v_valid = 1'b1; a_v = 4'b0011; a_v_bar = 4'b1100;
    repeat (4) begin
      @(posedge clk); #1;
      if (v_ready !== 1'b0 || m_ready !== 1'b1) bad_v++;
      if (out_valid !== 1'b0) bad_ov++;
    end
    v_valid = 1'b0; a_v = '0; a_v_bar = '0;
    checks++; if (bad_v !== 0) begin failures++; $display("FAIL hs_v_in_idle got=%0d bad cycles exp=0", bad_v); end
    checks++; if (bad_ov !== 0) begin failures++; $display("FAIL hs_no_result got=%0d pulses exp=0", bad_ov); end
    av = 4'b1111 ^ 4'b0101;
    exp_q.push_back(model(4'b1111, 3'b011));
    run_op(4'b0101, 3'b011, av, ~av, 2, 1'b1, lat, cyc, res, after, vrdy, mre);
    exp_v = exp_q.pop_front();
    checks++; if (vrdy !== 1'b1) begin failures++; $display("FAIL hs_v_ready got=%b exp=1", vrdy); end
    checks++; if (mre !== 1'b0) begin failures++; $display("FAIL hs_m_ready_eval got=%b exp=0", mre); end
    checks++; if (res !== exp_v) begin failures++; $display("FAIL hs_result got=%b exp=%b", res, exp_v); end
    checks++; if (after[3] !== 1'b0) begin failures++; $display("FAIL hs_pulse_width got=%b exp=0", after[3]); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] a, am;
    logic [N-2:0] rr;
    logic [2:0] exp_v, res;
    logic [3:0] after;
    int lat, cyc, vd;
    logic vrdy, mre;
    for (int i = 0; i < 10; i++) begin
      a  = 4'($urandom_range(0, 15));
      am = 4'($urandom_range(0, 15));
      rr = 3'($urandom_range(0, 7));
      vd = $urandom_range(0, 3);
      exp_q.push_back(model(a, rr));
      run_op(am, rr, a ^ am, ~(a ^ am), vd, 1'b0, lat, cyc, res, after, vrdy, mre);
      exp_v = exp_q.pop_front();
      checks++; if (res !== exp_v) begin failures++; $display("FAIL b2b_result i=%0d got=%b exp=%b", i, res, exp_v); end
      checks++; if (cyc !== LEVELS + 4 + vd) begin failures++; $display("FAIL b2b_cycles i=%0d got=%0d exp=%0d", i, cyc, LEVELS + 4 + vd); end
      checks++; if (after !== {1'b0, exp_v[2], 2'b00}) begin failures++; $display("FAIL b2b_precharge i=%0d got=%b exp=%b", i, after, {1'b0, exp_v[2], 2'b00}); end
    end
  endtask

  task automatic test_dr_check();
    logic [2:0] res;
    logic [3:0] after;
    int lat, cyc;
    logic vrdy, mre;
    run_op(4'b0000, 3'b000, 4'b0001, 4'b1111, 0, 1'b0, lat, cyc, res, after, vrdy, mre);
    checks++; if (dr_err !== DR_EN) begin failures++; $display("FAIL dr_set got=%b exp=%b", dr_err, DR_EN); end
    run_op(4'b0000, 3'b000, 4'b1111, 4'b0000, 0, 1'b0, lat, cyc, res, after, vrdy, mre);
    checks++; if (dr_err !== DR_EN) begin failures++; $display("FAIL dr_sticky got=%b exp=%b", dr_err, DR_EN); end
    checks++; if (res !== 3'b010) begin failures++; $display("FAIL dr_clean_result got=%b exp=010", res); end
    do_reset();
    checks++; if (dr_err !== 1'b0) begin failures++; $display("FAIL dr_reset got=%b exp=0", dr_err); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_mid_reset();
    test_exhaustive();
    test_handshake();
    test_back_to_back();
    test_dr_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
